dsp_share_arbiter: RTL and testbench
====================================

# dsp_share_arbiter

Round-robin arbiter and sequencer that shares one pipelined DSP48A1 multiply/accumulate datapath between two requesters. It accepts one operation per cycle from either requester and drives the operand, opmode and clock-enable inputs of the shared slice. It tracks every issued operation through the slice's pipeline depth and returns each result to the requester that issued it. Back-pressure from the response side freezes the whole pipeline.

## Interface
- WIDTH, 18: operand width (A, B).
- PWIDTH, 48: result width (P).
- LATENCY, 4: clock-enabled edges from the issue register to a valid dsp_p (range 1..8).
- IDLE_OPMODE, 8'h00: opmode driven on bubble cycles.

Clock is `clk`. Reset is `rst`: synchronous and active-high.

- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  operation request
- lock0 / lock1  in  1  keep the grant while the requester keeps requesting (accumulate chains)
- a0, b0 / a1, b1  in  WIDTH  operands
- op0 / op1  in  8  DSP48A1 opmode
- gnt0 / gnt1  out  1  combinational grant; operation accepted on an edge where reqN & gntN
- dsp_a, dsp_b  out  WIDTH  registered operands to the slice
- dsp_opmode  out  8  registered opmode to the slice
- dsp_ce  out  1  common clock enable for all slice pipeline registers
- dsp_rst  out  1  equals rst
- dsp_p  in  PWIDTH  slice result
- rsp_p  out  PWIDTH  equals dsp_p
- rsp_valid0 / rsp_valid1  out  1  result for requester N is on rsp_p
- rsp_ready0 / rsp_ready1  in  1  requester N accepts its result

## Operation
- Tracking pipe: valid and tag registers, stages v[0..LATENCY].
  - Stage 0 is the issue register, loaded together with dsp_a, dsp_b and dsp_opmode.
  - The pipe shifts only when dsp_ce = 1.
- Output: rsp_validN = v[LATENCY] & (tag[LATENCY] == N).
- Stall = v[LATENCY] & ~rsp_ready[tag[LATENCY]].
  - dsp_ce = ~stall.
  - While stalled: gnt0 = gnt1 = 0, and the issue register and pipe hold.
- Arbitration, when not stalled:
  - Only one requester: it wins.
  - Both requesting: the winner is the requester not granted last.
  - Lock exception: if the last accepted operation came from N, lockN = 1 and reqN = 1, N wins regardless of the other request.
- The `last` pointer updates only on an accepted operation.
- Accepted operation: stage 0 loads valid = 1, tag = N, dsp_a = aN, dsp_b = bN, dsp_opmode = opN.
- No acceptance (and not stalled): stage 0 loads valid = 0; dsp_opmode = IDLE_OPMODE; dsp_a and dsp_b hold.
- Locked chains must issue back-to-back. A bubble inside a chain drives IDLE_OPMODE, which clears the accumulator. That is a caller error and is not detected.
- Reset values:
  - gnt0 = gnt1 = 0, rsp_valid0 = rsp_valid1 = 0, dsp_ce = 1.
  - dsp_a = dsp_b = 0, dsp_opmode = IDLE_OPMODE, all v = 0, all tags = 0.
  - last = 1, so requester 0 wins the first contention.
- Reset mid-operation: all in-flight operations are discarded, no rsp_valid is produced for them, and any lock is released.

## Timing
- gnt is combinational from req, lock, last and stall in the same cycle.
- Operation accepted at edge k, no stalls:
  - dsp_* inputs are valid after edge k.
  - rsp_validN is high in the cycle after edge k+LATENCY.
- Each stalled cycle adds exactly one cycle. Ordering is strictly FIFO.
- Throughput: one operation per cycle. Results for different requesters may interleave on consecutive cycles.
- A result is consumed on an edge where rsp_validN & rsp_readyN. A ready with no valid is ignored.
- Simultaneous events:
  - A stall on edge k blocks acceptance on edge k, even with a request pending.
  - A request and its own completing result on the same edge are independent when not stalled.
- rst dominates every other input on the same edge.

## Test plan
- Single requester, LATENCY=4: req0 for 1 cycle (a0=3, b0=5, op0=8'h01), accepted at edge 1 -> dsp_a=3, dsp_b=5 after edge 1; rsp_valid0=1 after edge 5 only; rsp_valid1 never asserts.
- Contention: req0 = req1 = 1 for 4 cycles, no lock -> grants alternate 0,1,0,1 starting with 0 after reset; results return in the same 0,1,0,1 order with matching tags.
- Lock: req0 = lock0 = 1 for 3 cycles with req1 = 1 -> gnt0 on all 3 cycles; gnt1 first asserts the cycle after lock0 or req0 drops.
- Back-pressure: stream 6 ops from requester 1 and hold rsp_ready1 = 0 for 3 cycles once the first result arrives -> dsp_ce = 0 and gnt = 0 for exactly 3 cycles; all 6 results delivered in order with none lost or duplicated.
- Reset mid-flight: 3 ops in flight, rst = 1 for 1 cycle -> every output at its reset value after that edge; no rsp_valid afterwards; the next contention is won by requester 0.
- Idle: no requests for 10 cycles -> dsp_opmode = IDLE_OPMODE, dsp_ce = 1, rsp_valid0 = rsp_valid1 = 0 throughout.

Source files
------------

// File: rtl/dsp_share_arbiter.sv
// dsp_share_arbiter
// Round-robin arbiter and sequencer sharing one pipelined DSP48A1 MAC slice
// between two requesters. One operation per cycle is issued into the slice;
// a valid/tag pipe mirrors the slice latency so every result is steered back
// to the requester that issued it. Back-pressure on the result side freezes
// the slice and the tracking pipe together through a common clock enable.

module dsp_share_arbiter #(
    parameter int          WIDTH       = 18,
    parameter int          PWIDTH      = 48,
    parameter int          LATENCY     = 4,
    parameter logic [7:0]  IDLE_OPMODE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              lock0,
    input  logic [WIDTH-1:0]  a0,
    input  logic [WIDTH-1:0]  b0,
    input  logic [7:0]        op0,
    output logic              gnt0,

    input  logic              req1,
    input  logic              lock1,
    input  logic [WIDTH-1:0]  a1,
    input  logic [WIDTH-1:0]  b1,
    input  logic [7:0]        op1,
    output logic              gnt1,

    output logic [WIDTH-1:0]  dsp_a,
    output logic [WIDTH-1:0]  dsp_b,
    output logic [7:0]        dsp_opmode,
    output logic              dsp_ce,
    output logic              dsp_rst,
    input  logic [PWIDTH-1:0] dsp_p,

    output logic [PWIDTH-1:0] rsp_p,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    input  logic              rsp_ready0,
    input  logic              rsp_ready1
);

    // Tracking pipe: stage 0 is the issue register, stage LATENCY lines up
    // with a valid dsp_p. Tag 0/1 names the requester that issued the op.
    logic [LATENCY:0]   v_r;
    logic [LATENCY:0]   tag_r;
    logic               last_r;
    logic [WIDTH-1:0]   dsp_a_r;
    logic [WIDTH-1:0]   dsp_b_r;
    logic [7:0]         dsp_opmode_r;

    logic               out_ready_s;
    logic               stall_s;
    logic [1:0]         pick_s;
    logic               accept_s;
    logic               sel1_s;

    // Round-robin choice with lock override. Returns {grant1, grant0}.
    // A lock only holds the grant for the requester that won last; with a
    // single requester that requester always wins.
    function automatic logic [1:0] rr_pick(
        input logic r0,
        input logic r1,
        input logic l0,
        input logic l1,
        input logic last
    );
        logic [1:0] g;
        g = 2'b00;
        if (r0 && r1) begin
            if (!last && l0) begin
                g = 2'b01;
            end else if (last && l1) begin
                g = 2'b10;
            end else if (last) begin
                g = 2'b01;
            end else begin
                g = 2'b10;
            end
        end else begin
            g = {r1, r0};
        end
        return g;
    endfunction

    // Stall detection: the head result is present but its owner is not ready.
    always_comb begin
        out_ready_s = 1'b0;
        stall_s     = 1'b0;
        if (tag_r[LATENCY]) begin
            out_ready_s = rsp_ready1;
        end else begin
            out_ready_s = rsp_ready0;
        end
        stall_s = v_r[LATENCY] & ~out_ready_s;
    end

    // Grant generation: nothing is granted while stalled or in reset.
    always_comb begin
        pick_s = 2'b00;
        if (rst || stall_s) begin
            pick_s = 2'b00;
        end else begin
            pick_s = rr_pick(req0, req1, lock0, lock1, last_r);
        end
        accept_s = pick_s[0] | pick_s[1];
        sel1_s   = pick_s[1];
    end

    // Issue register, tracking pipe and round-robin pointer; all advance
    // only on clock-enabled edges so they stay aligned with the slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r          <= '0;
            tag_r        <= '0;
            last_r       <= 1'b1;
            dsp_a_r      <= '0;
            dsp_b_r      <= '0;
            dsp_opmode_r <= IDLE_OPMODE;
        end else if (!stall_s) begin
            v_r   <= {v_r[LATENCY-1:0], accept_s};
            tag_r <= {tag_r[LATENCY-1:0], sel1_s};
            if (accept_s) begin
                last_r <= sel1_s;
                if (sel1_s) begin
                    dsp_a_r      <= a1;
                    dsp_b_r      <= b1;
                    dsp_opmode_r <= op1;
                end else begin
                    dsp_a_r      <= a0;
                    dsp_b_r      <= b0;
                    dsp_opmode_r <= op0;
                end
            end else begin
                // Bubble: operands hold, opmode idles the slice.
                dsp_opmode_r <= IDLE_OPMODE;
            end
        end else begin
            v_r          <= v_r;
            tag_r        <= tag_r;
            last_r       <= last_r;
            dsp_a_r      <= dsp_a_r;
            dsp_b_r      <= dsp_b_r;
            dsp_opmode_r <= dsp_opmode_r;
        end
    end

    assign gnt0       = pick_s[0];
    assign gnt1       = pick_s[1];
    assign dsp_a      = dsp_a_r;
    assign dsp_b      = dsp_b_r;
    assign dsp_opmode = dsp_opmode_r;
    assign dsp_ce     = ~stall_s;
    assign dsp_rst    = rst;
    assign rsp_p      = dsp_p;
    assign rsp_valid0 = v_r[LATENCY] & ~tag_r[LATENCY];
    assign rsp_valid1 = v_r[LATENCY] &  tag_r[LATENCY];

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Self-checking bench for dsp_share_arbiter: a table of per-cycle vectors
// for single-requester, contention and lock behaviour, followed by
// hand-written sequences for back-pressure, idle and reset mid-flight.
// A small behavioural model of the DSP slice (product pipeline gated by
// dsp_ce) drives dsp_p so returned data can be checked against operands.

module tb_dsp_share_arbiter;

    localparam int LAT = 4;

    logic         clk;
    logic         rst;
    logic         req0, lock0, req1, lock1;
    logic [17:0]  a0, b0, a1, b1;
    logic [7:0]   op0, op1;
    logic         gnt0, gnt1;
    logic [17:0]  dsp_a, dsp_b;
    logic [7:0]   dsp_opmode;
    logic         dsp_ce, dsp_rst;
    logic [47:0]  dsp_p;
    logic [47:0]  rsp_p;
    logic         rsp_valid0, rsp_valid1;
    logic         rsp_ready0, rsp_ready1;

    int n_checks;
    int n_err;

    dsp_share_arbiter #(
        .WIDTH(18), .PWIDTH(48), .LATENCY(LAT), .IDLE_OPMODE(8'h00)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .lock0(lock0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0),
        .req1(req1), .lock1(lock1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p),
        .rsp_p(rsp_p), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: product enters stage 1 one enabled edge after issue and
    // reaches stage LAT when the arbiter's tracking pipe reaches its head.
    logic [47:0] pm [1:LAT];
    always @(posedge clk) begin
        if (dsp_rst) begin
            for (int i = 1; i <= LAT; i++) pm[i] <= 48'd0;
        end else if (dsp_ce) begin
            pm[1] <= 48'(dsp_a) * 48'(dsp_b);
            for (int i = 2; i <= LAT; i++) pm[i] <= pm[i-1];
        end
    end
    assign dsp_p = pm[LAT];

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        req0, lock0, req1, lock1;
        logic [17:0] a0, b0, a1, b1;
        logic [7:0]  op0, op1;
        logic        e_g0, e_g1, e_rv0, e_rv1;
        logic [17:0] e_a, e_b;
        logic [7:0]  e_op;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input int rs,
        input int r0, input int l0, input int xa0, input int xb0, input int xo0,
        input int r1, input int l1, input int xa1, input int xb1, input int xo1,
        input int g0, input int g1, input int v0, input int v1,
        input int ea, input int eb, input int eo
    );
        vec_t t;
        t.rst = 1'(rs);
        t.req0 = 1'(r0); t.lock0 = 1'(l0); t.a0 = 18'(xa0); t.b0 = 18'(xb0); t.op0 = 8'(xo0);
        t.req1 = 1'(r1); t.lock1 = 1'(l1); t.a1 = 18'(xa1); t.b1 = 18'(xb1); t.op1 = 8'(xo1);
        t.e_g0 = 1'(g0); t.e_g1 = 1'(g1); t.e_rv0 = 1'(v0); t.e_rv1 = 1'(v1);
        t.e_a = 18'(ea); t.e_b = 18'(eb); t.e_op = 8'(eo);
        return t;
    endfunction

    function automatic vec_t idle(input int v0, input int v1, input int ea, input int eb);
        return mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,v0,v1, ea,eb,0);
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        a0 = 18'd0; b0 = 18'd0; a1 = 18'd0; b1 = 18'd0; op0 = 8'h00; op1 = 8'h00;
        rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        rst = t.rst; req0 = t.req0; lock0 = t.lock0; req1 = t.req1; lock1 = t.lock1;
        a0 = t.a0; b0 = t.b0; a1 = t.a1; b1 = t.b1; op0 = t.op0; op1 = t.op1;
        #2;
        chk($sformatf("v%0d gnt0", idx), {47'd0, gnt0}, {47'd0, t.e_g0});
        chk($sformatf("v%0d gnt1", idx), {47'd0, gnt1}, {47'd0, t.e_g1});
        chk($sformatf("v%0d dsp_ce", idx), {47'd0, dsp_ce}, 48'd1);
        chk($sformatf("v%0d rsp_valid0", idx), {47'd0, rsp_valid0}, {47'd0, t.e_rv0});
        chk($sformatf("v%0d rsp_valid1", idx), {47'd0, rsp_valid1}, {47'd0, t.e_rv1});
        next_edge();
        chk($sformatf("v%0d dsp_a", idx), 48'(dsp_a), 48'(t.e_a));
        chk($sformatf("v%0d dsp_b", idx), 48'(dsp_b), 48'(t.e_b));
        chk($sformatf("v%0d dsp_opmode", idx), 48'(dsp_opmode), 48'(t.e_op));
    endtask

    initial begin
        logic [14:0] bp_g;
        logic [14:0] bp_ce;
        logic [14:0] bp_rv;
        n_checks = 0;
        n_err    = 0;

        // Single requester: accepted at edge 1, result seen after edge 5 only.
        tbl.push_back(mk(0, 1,0,3,5,8'h01, 0,0,0,0,0, 1,0,0,0, 3,5,8'h01));
        tbl.push_back(idle(0,0,3,5));
        tbl.push_back(idle(0,0,3,5));
        tbl.push_back(idle(0,0,3,5));
        tbl.push_back(idle(0,0,3,5));
        tbl.push_back(idle(1,0,3,5));
        tbl.push_back(idle(0,0,3,5));
        // Reset so the next contention starts from last = 1.
        tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0));
        // Contention without lock: 0,1,0,1 then results in the same order.
        tbl.push_back(mk(0, 1,0,10,11,8'h01, 1,0,20,21,8'h02, 1,0,0,0, 10,11,8'h01));
        tbl.push_back(mk(0, 1,0,12,13,8'h01, 1,0,22,23,8'h02, 0,1,0,0, 22,23,8'h02));
        tbl.push_back(mk(0, 1,0,14,15,8'h01, 1,0,24,25,8'h02, 1,0,0,0, 14,15,8'h01));
        tbl.push_back(mk(0, 1,0,16,17,8'h01, 1,0,26,27,8'h02, 0,1,0,0, 26,27,8'h02));
        tbl.push_back(idle(0,0,26,27));
        tbl.push_back(idle(1,0,26,27));
        tbl.push_back(idle(0,1,26,27));
        tbl.push_back(idle(1,0,26,27));
        tbl.push_back(idle(0,1,26,27));
        tbl.push_back(idle(0,0,26,27));
        // Lock: requester 0 keeps the grant for 3 cycles, then 1 wins.
        tbl.push_back(mk(0, 1,1,30,31,8'h05, 1,0,40,41,8'h06, 1,0,0,0, 30,31,8'h05));
        tbl.push_back(mk(0, 1,1,32,33,8'h05, 1,0,40,41,8'h06, 1,0,0,0, 32,33,8'h05));
        tbl.push_back(mk(0, 1,1,34,35,8'h05, 1,0,40,41,8'h06, 1,0,0,0, 34,35,8'h05));
        tbl.push_back(mk(0, 1,0,36,37,8'h05, 1,0,40,41,8'h06, 0,1,0,0, 40,41,8'h06));
        // lock0 is ignored when requester 1 won last.
        tbl.push_back(mk(0, 1,1,38,39,8'h05, 1,0,42,43,8'h06, 1,0,0,0, 38,39,8'h05));
        // lock1 is ignored until 1 wins; once it has, it holds against lock0.
        tbl.push_back(mk(0, 1,0,44,45,8'h05, 1,1,46,47,8'h06, 0,1,1,0, 46,47,8'h06));
        tbl.push_back(mk(0, 1,1,48,49,8'h05, 1,1,50,51,8'h06, 0,1,1,0, 50,51,8'h06));
        tbl.push_back(idle(1,0,50,51));
        tbl.push_back(idle(0,1,50,51));
        tbl.push_back(idle(1,0,50,51));
        tbl.push_back(idle(0,1,50,51));
        tbl.push_back(idle(0,1,50,51));
        tbl.push_back(idle(0,0,50,51));

        // Power-on reset and reset-state checks.
        clear_inputs();
        rst = 1'b1;
        next_edge();
        chk("dsp_rst follows rst", {47'd0, dsp_rst}, 48'd1);
        next_edge();
        rst = 1'b0;
        #1;
        chk("reset gnt0", {47'd0, gnt0}, 48'd0);
        chk("reset gnt1", {47'd0, gnt1}, 48'd0);
        chk("reset rsp_valid0", {47'd0, rsp_valid0}, 48'd0);
        chk("reset rsp_valid1", {47'd0, rsp_valid1}, 48'd0);
        chk("reset dsp_ce", {47'd0, dsp_ce}, 48'd1);
        chk("reset dsp_a", 48'(dsp_a), 48'd0);
        chk("reset dsp_b", 48'(dsp_b), 48'd0);
        chk("reset dsp_opmode", 48'(dsp_opmode), 48'd0);
        chk("dsp_rst low", {47'd0, dsp_rst}, 48'd0);
        #0;
        @(negedge clk);
        @(posedge clk);
        #1;
        // Table rows start at posedge+1.
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Back-pressure: six ops from requester 1, ready held low 3 cycles
        // once the first result shows up. Bit r of each mask is row r.
        clear_inputs();
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        bp_g  = 15'b000000100011111;
        bp_ce = 15'b111111100011111;
        bp_rv = 15'b011111111100000;
        for (int r = 0; r < 15; r++) begin
            int k;
            int idx;
            k = (r < 5) ? r : 5;
            idx = (r <= 8) ? 0 : r - 8;
            req1 = (r <= 8) ? 1'b1 : 1'b0;
            a1 = 18'(50 + k);
            b1 = 18'(60 + k);
            op1 = 8'h03;
            rsp_ready1 = (r >= 5 && r <= 7) ? 1'b0 : 1'b1;
            #2;
            chk($sformatf("bp%0d gnt1", r), {47'd0, gnt1}, {47'd0, bp_g[r]});
            chk($sformatf("bp%0d gnt0", r), {47'd0, gnt0}, 48'd0);
            chk($sformatf("bp%0d dsp_ce", r), {47'd0, dsp_ce}, {47'd0, bp_ce[r]});
            chk($sformatf("bp%0d rsp_valid1", r), {47'd0, rsp_valid1}, {47'd0, bp_rv[r]});
            chk($sformatf("bp%0d rsp_valid0", r), {47'd0, rsp_valid0}, 48'd0);
            if (bp_rv[r]) begin
                chk($sformatf("bp%0d rsp_p", r), rsp_p, 48'((50 + idx) * (60 + idx)));
            end
            next_edge();
            if (r == 8) chk("bp last issue dsp_a", 48'(dsp_a), 48'd55);
        end

        // Idle: nothing requested for 10 cycles.
        clear_inputs();
        for (int r = 0; r < 10; r++) begin
            #2;
            chk($sformatf("idle%0d dsp_ce", r), {47'd0, dsp_ce}, 48'd1);
            chk($sformatf("idle%0d rsp_valid0", r), {47'd0, rsp_valid0}, 48'd0);
            chk($sformatf("idle%0d rsp_valid1", r), {47'd0, rsp_valid1}, 48'd0);
            next_edge();
            chk($sformatf("idle%0d dsp_opmode", r), 48'(dsp_opmode), 48'h00);
        end

        // Reset mid-flight: three locked ops from requester 0, then reset
        // with both requests pending.
        for (int r = 0; r < 3; r++) begin
            req0 = 1'b1; lock0 = 1'b1;
            a0 = 18'(70 + r); b0 = 18'd80; op0 = 8'h01;
            #2;
            chk($sformatf("rmf%0d gnt0", r), {47'd0, gnt0}, 48'd1);
            next_edge();
        end
        rst = 1'b1; req1 = 1'b1; a1 = 18'd90; b1 = 18'd91; op1 = 8'h02;
        next_edge();
        clear_inputs();
        #1;
        chk("rmf gnt0", {47'd0, gnt0}, 48'd0);
        chk("rmf gnt1", {47'd0, gnt1}, 48'd0);
        chk("rmf rsp_valid0", {47'd0, rsp_valid0}, 48'd0);
        chk("rmf rsp_valid1", {47'd0, rsp_valid1}, 48'd0);
        chk("rmf dsp_ce", {47'd0, dsp_ce}, 48'd1);
        chk("rmf dsp_a", 48'(dsp_a), 48'd0);
        chk("rmf dsp_b", 48'(dsp_b), 48'd0);
        chk("rmf dsp_opmode", 48'(dsp_opmode), 48'h00);
        for (int r = 0; r < 7; r++) begin
            next_edge();
            chk($sformatf("rmf drain%0d rsp_valid0", r), {47'd0, rsp_valid0}, 48'd0);
            chk($sformatf("rmf drain%0d rsp_valid1", r), {47'd0, rsp_valid1}, 48'd0);
        end
        req0 = 1'b1; req1 = 1'b1;
        a0 = 18'd7; b0 = 18'd9; op0 = 8'h01;
        a1 = 18'd11; b1 = 18'd13; op1 = 8'h02;
        #2;
        chk("post-reset contention gnt0", {47'd0, gnt0}, 48'd1);
        chk("post-reset contention gnt1", {47'd0, gnt1}, 48'd0);
        next_edge();
        chk("post-reset contention dsp_a", 48'(dsp_a), 48'd7);
        clear_inputs();
        next_edge();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
